// File: rtl/dp_pkg.sv
// Shared datapath constants, the responder state type and an address range helper.
package dp_pkg;

    localparam int WORD_W              = 32;
    localparam int DEF_DEPTH_WORDS     = 64;
    localparam int DEF_WAIT_CYCLES     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // True when the byte address falls at or beyond the end of a depth-word array.
    function automatic logic addr_oob(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return addr[WORD_W-1:2] >= depth[WORD_W-3:0];
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bus between the MEM stage (master) and the data memory responder (slave).
interface dmem_resp_if;
    import dp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_read;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_read, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for dmem_resp: synchronous write, registered read, contents never reset.
module dmem_array
    import dp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data memory responder with WAIT_CYCLES wait states; DMEM_ALIGN_CHECK_EN makes misaligned addresses errors.
//   state | meaning
//   IDLE  | ready for a request (req_ready=1 once out of reset)
//   WAIT  | request captured, counting down wait states
//   RESP  | response presented, held until rsp_ready
module dmem_resp
    import dp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_resp_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              r_live;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_read;
    logic              r_write;
    logic              r_err;
    logic              r_rsp_load;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_in_misalign;
    logic              w_in_err;
    logic              w_in_idle;
    logic [AW-1:0]     w_cur_idx;
    logic [WORD_W-1:0] w_cur_wdata;
    logic              w_cur_read;
    logic              w_cur_write;
    logic              w_cur_err;
    logic              w_enter_resp;
    logic              w_we;
    logic              w_re;
    logic [WORD_W-1:0] w_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_in_misalign = |bus.req_addr[1:0];
`else
    logic w_unused_lsb;
    assign w_unused_lsb  = ^bus.req_addr[1:0];
    assign w_in_misalign = 1'b0;
`endif

    assign w_in_err = (bus.req_read == bus.req_write)
                    || addr_oob(bus.req_addr, DEPTH_WORDS)
                    || w_in_misalign;

    // r_live keeps req_ready low until the first edge after reset release.
    assign w_in_idle = (r_state == IDLE);
    assign w_accept  = bus.req_valid && bus.req_ready;

    // With zero wait states the array is accessed on the accept edge itself,
    // before the capture registers hold the request.
    assign w_cur_idx   = w_in_idle ? bus.req_addr[AW+1:2] : r_idx;
    assign w_cur_wdata = w_in_idle ? bus.req_wdata        : r_wdata;
    assign w_cur_read  = w_in_idle ? bus.req_read         : r_read;
    assign w_cur_write = w_in_idle ? bus.req_write        : r_write;
    assign w_cur_err   = w_in_idle ? w_in_err             : r_err;

    assign w_we = w_enter_resp && w_cur_write && !w_cur_err;
    assign w_re = w_enter_resp && w_cur_read  && !w_cur_err;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next     = WAIT;
                        w_cnt_next = WAIT_LOAD;
                    end else begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_live     <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_rsp_load <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_idx   <= bus.req_addr[AW+1:2];
                r_wdata <= bus.req_wdata;
                r_read  <= bus.req_read;
                r_write <= bus.req_write;
                r_err   <= w_in_err;
            end
            if (w_enter_resp) begin
                r_rsp_load <= w_re;
                r_rsp_err  <= w_cur_err;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_q)
    );

    assign bus.req_ready = r_live && w_in_idle;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) && r_rsp_err;
    assign bus.rsp_rdata = ((r_state == RESP) && r_rsp_load) ? w_q : '0;

endmodule
